// File: rtl/telem_tx.sv
// telem_tx: periodic UART telemetry frame (AA 55 batt torque curr), 8N1, LSB first.
// Optional macro TELEM_CHKSUM_EN appends a 9th byte: mod-256 sum of bytes 2..7.
module telem_tx #(
    parameter int BAUD_DIV    = 2604,
    parameter int PERIOD_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] batt,
    input  logic [11:0] avg_torque,
    input  logic [11:0] avg_curr,
    output logic        TX,
    output logic        busy,
    output logic        frm_done
);
`ifdef TELEM_CHKSUM_EN
    localparam int IW = 4;
    localparam int NB = 9;
`else
    localparam int IW = 3;
    localparam int NB = 8;
`endif
    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BPRE  = BW'(BAUD_DIV - 2);
    localparam logic [IW-1:0] LAST  = IW'(NB - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [PERIOD_BITS-1:0] per_q;
    logic [BW-1:0]          baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [7:0]             sh_q, sh_d;
    logic                   tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic [11:0]            batt_q, batt_d, torq_q, torq_d, curr_q, curr_d;
    logic                   req;
    logic [NB-1:0][7:0]     frm_b;

    assign req      = &per_q;
    assign TX       = tx_q;
    assign busy     = busy_q;
    assign frm_done = done_q;

`ifdef TELEM_CHKSUM_EN
    logic [7:0] chk;
    assign chk   = {4'h0, batt_q[11:8]} + batt_q[7:0] + {4'h0, torq_q[11:8]} + torq_q[7:0]
                 + {4'h0, curr_q[11:8]} + curr_q[7:0];
    assign frm_b = {chk, curr_q[7:0], {4'h0, curr_q[11:8]}, torq_q[7:0], {4'h0, torq_q[11:8]},
                    batt_q[7:0], {4'h0, batt_q[11:8]}, 8'h55, 8'hAA};
`else
    assign frm_b = {curr_q[7:0], {4'h0, curr_q[11:8]}, torq_q[7:0], {4'h0, torq_q[11:8]},
                    batt_q[7:0], {4'h0, batt_q[11:8]}, 8'h55, 8'hAA};
`endif

    // State, counters, snapshots and registered line outputs; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            batt_q  <= '0;
            torq_q  <= '0;
            curr_q  <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_q + 1'b1;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            batt_q  <= batt_d;
            torq_q  <= torq_d;
            curr_q  <= curr_d;
        end
    end

    // Next state: the inter-byte stop bit ends one clock early so the LOAD clock completes it.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        batt_d  = batt_q;
        torq_d  = torq_q;
        curr_d  = curr_q;
        case (state_q)
            IDLE: begin
                idx_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (req) begin
                    state_d = LOAD;
                    batt_d  = batt;
                    torq_d  = avg_torque;
                    curr_d  = avg_curr;
                end
            end
            LOAD: begin
                sh_d    = frm_b[idx_q];
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                baud_d = baud_q + 1'b1;
                if (bit_q == 4'd9 && idx_q != LAST && baud_q == BPRE) begin
                    state_d = LOAD;
                    idx_d   = idx_q + 1'b1;
                end else if (baud_q == BLAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = sh_q[0];
                        sh_d  = {1'b1, sh_q[7:1]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_telem_tx.sv
// tb_telem_tx: random-stimulus bench comparing sampled TX/busy/frm_done waveforms to an ideal frame model.
module tb_telem_tx;
    localparam int BD = 4;
`ifdef TELEM_CHKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int BL = 10 * BD;
    localparam int FL = NB * BL;
    localparam int MAXN = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] batt, torq, curr, batt8, torq8, curr8;
    logic        tx10, busy10, done10, tx8, busy8, done8;

    telem_tx #(.BAUD_DIV(BD), .PERIOD_BITS(10)) dut (
        .clk(clk), .rst(rst), .batt(batt), .avg_torque(torq), .avg_curr(curr),
        .TX(tx10), .busy(busy10), .frm_done(done10));

    telem_tx #(.BAUD_DIV(BD), .PERIOD_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .batt(batt8), .avg_torque(torq8), .avg_curr(curr8),
        .TX(tx8), .busy(busy8), .frm_done(done8));

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    int         done_cnt = 0;
    logic       s_tx [0:MAXN];
    logic       s_busy [0:MAXN];
    logic       s_done [0:MAXN];
    logic       e_tx [0:MAXN];
    logic       e_busy [0:MAXN];
    logic       e_done [0:MAXN];
    logic [7:0] exp_b [9];
    int         frames [$];

    always @(negedge clk) done_cnt <= done_cnt + (done10 ? 1 : 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic rnd_in();
        batt = 12'($urandom);
        torq = 12'($urandom);
        curr = 12'($urandom);
    endtask

    task automatic set_bytes(input logic [11:0] b, input logic [11:0] t, input logic [11:0] c);
        int sum;
        exp_b[0] = 8'hAA;
        exp_b[1] = 8'h55;
        exp_b[2] = 8'(b >> 8);
        exp_b[3] = 8'(b);
        exp_b[4] = 8'(t >> 8);
        exp_b[5] = 8'(t);
        exp_b[6] = 8'(c >> 8);
        exp_b[7] = 8'(c);
        sum = 0;
        for (int k = 2; k < 8; k++) sum += int'(exp_b[k]);
        exp_b[8] = 8'(sum % 256);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx10}, 1);
        check("rst_busy", {31'd0, busy10}, 0);
        check("rst_done", {31'd0, done10}, 0);
        check("rst_tx8", {31'd0, tx8}, 1);
        check("rst_busy8", {31'd0, busy8}, 0);
        rst = 1'b0;
    endtask

    // Sample index c holds the outputs just after the c-th rising edge following reset release.
    task automatic capture(input bit sel, input int n, input int chg_at);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            @(negedge clk);
            s_tx[c]   = sel ? tx8 : tx10;
            s_busy[c] = sel ? busy8 : busy10;
            s_done[c] = sel ? done8 : done10;
            if (c == chg_at) rnd_in();
        end
    endtask

    // Ideal behaviour: requests every 2^pbits edges, accepted only once the previous frame has ended;
    // a frame's line is low from one edge after the request and busy covers exactly FL clocks.
    task automatic model(input int pbits, input int n);
        int last_end;
        int k;
        int j;
        frames.delete();
        for (int c = 0; c <= n; c++) begin
            e_tx[c] = 1'b1;
            e_busy[c] = 1'b0;
            e_done[c] = 1'b0;
        end
        last_end = -1;
        for (int r = 1 << pbits; r < n; r += 1 << pbits) begin
            if (r > last_end) begin
                frames.push_back(r);
                for (int i = 1; i <= FL && r + i <= n; i++) begin
                    k = (i - 1) / BL;
                    j = ((i - 1) % BL) / BD;
                    e_tx[r + i] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[k][j - 1];
                    e_busy[r + i] = 1'b1;
                end
                if (r + FL + 1 <= n) e_done[r + FL + 1] = 1'b1;
                last_end = r + FL + 1;
            end
        end
    endtask

    task automatic compare(input string tag, input int n);
        int mtx, mbusy, mdone, lat, nb, r;
        logic [7:0] v;
        mtx = 0; mbusy = 0; mdone = 0;
        for (int c = 1; c <= n; c++) begin
            if (s_tx[c] !== e_tx[c]) mtx++;
            if (s_busy[c] !== e_busy[c]) mbusy++;
            if (s_done[c] !== e_done[c]) mdone++;
        end
        check({tag, "_tx_wave_mismatches"}, mtx, 0);
        check({tag, "_busy_wave_mismatches"}, mbusy, 0);
        check({tag, "_done_wave_mismatches"}, mdone, 0);
        foreach (frames[f]) begin
            r = frames[f];
            if (r + FL + 1 <= n) begin
                lat = -1;
                for (int c = r; c <= r + FL && lat < 0; c++) if (s_tx[c] === 1'b0) lat = c - r;
                check($sformatf("%s_f%0d_start_latency", tag, f), lat, 1);
                nb = 0;
                for (int c = r; c <= r + FL + 1; c++) if (s_busy[c] === 1'b1) nb++;
                check($sformatf("%s_f%0d_busy_len", tag, f), nb, FL);
                for (int k = 0; k < NB; k++) begin
                    for (int j = 1; j <= 8; j++) v[j - 1] = s_tx[r + 1 + k * BL + j * BD + BD / 2];
                    check($sformatf("%s_f%0d_byte%0d", tag, f, k), {24'd0, v}, {24'd0, exp_b[k]});
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        batt = 12'hABC;
        torq = 12'h123;
        curr = 12'h7FF;
        batt8 = 12'($urandom);
        torq8 = 12'($urandom);
        curr8 = 12'($urandom);

        // Short period: the middle request falls inside a frame and must be dropped.
        do_reset();
        set_bytes(batt8, torq8, curr8);
        capture(1'b1, 1200, -1);
        model(8, 1200);
        compare("p8", 1200);

        // Reference frame with the fixed example values.
        do_reset();
        set_bytes(batt, torq, curr);
        capture(1'b0, 1400, -1);
        model(10, 1400);
        compare("gold", 1400);

        // Inputs change one clock after the request; frame keeps the captured snapshot.
        rnd_in();
        set_bytes(batt, torq, curr);
        do_reset();
        capture(1'b0, 1400, 1024);
        model(10, 1400);
        compare("chg", 1400);

        for (int t = 0; t < 3; t++) begin
            rnd_in();
            set_bytes(batt, torq, curr);
            do_reset();
            capture(1'b0, 1400, -1);
            model(10, 1400);
            compare($sformatf("rnd%0d", t), 1400);
        end

        // Reset lands during the start bit of byte 3.
        rnd_in();
        set_bytes(batt, torq, curr);
        do_reset();
        capture(1'b0, 1146, -1);
        model(10, 1146);
        compare("pre", 1146);
        check("pre_tx_low", {31'd0, tx10}, 0);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("abort_tx", {31'd0, tx10}, 1);
        check("abort_busy", {31'd0, busy10}, 0);
        do_reset();
        check("abort_no_done", done_cnt, d0);
        capture(1'b0, 1400, -1);
        model(10, 1400);
        compare("post", 1400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
